// File: rtl/hit_score_tracker.sv
// hit_score_tracker: turns per-bullet enemy hit vectors into weighted points,
// drains them one unit per clock into a saturating 4-digit BCD score, and
// plays a retriggerable one-shot square-wave hit tone.
module hit_score_tracker #(
  parameter int unsigned BULLET_COUNT = 8,
  parameter int unsigned PTS_FLY      = 1,
  parameter int unsigned PTS_MOSQUITO = 2,
  parameter int unsigned PTS_SPIDER   = 5,
  parameter int unsigned HALF_PERIOD  = 12500,
  parameter int unsigned HIT_CYCLES   = 2500000
) (
  input  logic                    clk25,
  input  logic                    reset_n,
  input  logic                    clear_score,
  input  logic [BULLET_COUNT-1:0] bullet_hit_fly,
  input  logic [BULLET_COUNT-1:0] bullet_hit_mosquito,
  input  logic [BULLET_COUNT-1:0] bullet_hit_spider,
  output logic [15:0]             score_bcd,
  output logic                    score_busy,
  output logic                    score_max,
  output logic                    hit_buzz
);

  localparam int unsigned ADD_W  = 17;
  localparam int unsigned SUM_W  = 18;
  localparam int unsigned PEND_W = 16;
  localparam int unsigned DUR_W  = $clog2(HIT_CYCLES + 1);
  localparam int unsigned PH_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [15:0]       SCORE_TOP = 16'h9999;
  localparam logic [SUM_W-1:0]  PEND_SAT  = SUM_W'(17'h0FFFF);

  // Number of set bits in one hit vector.
  function automatic logic [ADD_W-1:0] popcount(input logic [BULLET_COUNT-1:0] v);
    logic [ADD_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(BULLET_COUNT); i++) begin
      c = c + ADD_W'(v[i]);
    end
    return c;
  endfunction

  // One BCD unit increment with digit-to-digit carry ripple.
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pending_nxt;
  logic [15:0]       score_nxt;
  logic [ADD_W-1:0]  add_pts;
  logic [SUM_W-1:0]  pend_sum;
  logic              sat;
  logic              dec;
  logic              any_hit;

  logic [DUR_W-1:0]  dur_cnt;
  logic [DUR_W-1:0]  dur_nxt;
  logic [PH_W-1:0]   ph_cnt;
  logic [PH_W-1:0]   ph_nxt;
  logic              buzz_nxt;

  // Weighted points arriving this cycle and whether any bullet hit anything.
  always_comb begin
    add_pts = popcount(bullet_hit_fly)      * ADD_W'(PTS_FLY)
            + popcount(bullet_hit_mosquito) * ADD_W'(PTS_MOSQUITO)
            + popcount(bullet_hit_spider)   * ADD_W'(PTS_SPIDER);
    any_hit = (|bullet_hit_fly) | (|bullet_hit_mosquito) | (|bullet_hit_spider);
  end

  // Pending accumulator and score drain; clear wins, saturation empties pending.
  always_comb begin
    sat         = (score_bcd == SCORE_TOP);
    dec         = (pending != '0) && !sat;
    pend_sum    = SUM_W'(pending) - SUM_W'(dec) + SUM_W'(add_pts);
    score_nxt   = score_bcd;
    pending_nxt = pending;
    if (clear_score) begin
      score_nxt   = '0;
      pending_nxt = '0;
    end else begin
      if (dec) begin
        score_nxt = bcd_inc(score_bcd);
      end
      if (sat || (score_nxt == SCORE_TOP)) begin
        pending_nxt = '0;
      end else if (pend_sum > PEND_SAT) begin
        pending_nxt = '1;
      end else begin
        pending_nxt = pend_sum[PEND_W-1:0];
      end
    end
  end

  // Score state and status flags.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      score_bcd  <= '0;
      pending    <= '0;
      score_busy <= 1'b0;
      score_max  <= 1'b0;
    end else begin
      score_bcd  <= score_nxt;
      pending    <= pending_nxt;
      score_busy <= (pending_nxt != '0);
      score_max  <= (score_nxt == SCORE_TOP);
    end
  end

  // Tone sequencing: any hit restarts a full-length tone in its high phase.
  always_comb begin
    dur_nxt  = dur_cnt;
    ph_nxt   = ph_cnt;
    buzz_nxt = hit_buzz;
    if (any_hit) begin
      dur_nxt  = DUR_W'(HIT_CYCLES);
      ph_nxt   = '0;
      buzz_nxt = 1'b1;
    end else if (dur_cnt != '0) begin
      dur_nxt = dur_cnt - DUR_W'(1);
      if (ph_cnt == PH_W'(HALF_PERIOD - 1)) begin
        ph_nxt   = '0;
        buzz_nxt = ~hit_buzz;
      end else begin
        ph_nxt = ph_cnt + PH_W'(1);
      end
    end else begin
      ph_nxt   = '0;
      buzz_nxt = 1'b0;
    end
  end

  // Tone state registers.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      dur_cnt  <= '0;
      ph_cnt   <= '0;
      hit_buzz <= 1'b0;
    end else begin
      dur_cnt  <= dur_nxt;
      ph_cnt   <= ph_nxt;
      hit_buzz <= buzz_nxt;
    end
  end

endmodule

// File: tb/tb_hit_score_tracker.sv
// Directed bench for hit_score_tracker with a score scoreboard and tone model.
module tb_hit_score_tracker;

  localparam int HALF = 4;
  localparam int HIT  = 20;

  logic        clk25;
  logic        reset_n;
  logic        clear_score;
  logic [7:0]  fly;
  logic [7:0]  mosq;
  logic [7:0]  spid;
  logic [15:0] score_bcd;
  logic        score_busy;
  logic        score_max;
  logic        hit_buzz;

  int n_vec = 0;
  int n_err = 0;
  int model_score = 0;
  int exp_q[$];

  hit_score_tracker #(
    .BULLET_COUNT(8),
    .PTS_FLY(1),
    .PTS_MOSQUITO(2),
    .PTS_SPIDER(5),
    .HALF_PERIOD(HALF),
    .HIT_CYCLES(HIT)
  ) dut (
    .clk25(clk25),
    .reset_n(reset_n),
    .clear_score(clear_score),
    .bullet_hit_fly(fly),
    .bullet_hit_mosquito(mosq),
    .bullet_hit_spider(spid),
    .score_bcd(score_bcd),
    .score_busy(score_busy),
    .score_max(score_max),
    .hit_buzz(hit_buzz)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Tone level k edges after the most recent hit edge.
  function automatic logic exp_buzz(input int k);
    if (k > HIT) return 1'b0;
    return ((k / HALF) % 2) == 0;
  endfunction

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  // Drive one cycle of stimulus and push the expected settled score.
  task automatic pulse(input logic [7:0] f, input logic [7:0] m, input logic [7:0] s,
                       input logic clr);
    int add;
    fly = f; mosq = m; spid = s; clear_score = clr;
    tick();
    fly = '0; mosq = '0; spid = '0; clear_score = 1'b0;
    add = $countones(f) * 1 + $countones(m) * 2 + $countones(s) * 5;
    if (clr) model_score = 0;
    else if (model_score + add > 9999) model_score = 9999;
    else model_score = model_score + add;
    exp_q.push_back(model_score);
  endtask

  // Wait for the drain to finish, then retire scoreboard entries.
  task automatic drain_check(input string tag);
    int cnt;
    int e;
    cnt = 0;
    while (score_busy && cnt < 20000) begin
      tick();
      cnt++;
    end
    chk({tag, "_idle"}, 32'(score_busy), 32'd0);
    e = model_score;
    while (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, 32'(score_bcd), 32'(to_bcd(e)));
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0; clear_score = 1'b0; fly = '0; mosq = '0; spid = '0;

    // Reset state.
    #2;
    chk("rst_score", 32'(score_bcd), 32'd0);
    chk("rst_busy",  32'(score_busy), 32'd0);
    chk("rst_max",   32'(score_max), 32'd0);
    chk("rst_buzz",  32'(hit_buzz), 32'd0);
    @(negedge clk25);
    @(negedge clk25);
    reset_n = 1'b1;
    tick();

    // Single fly hit: pending after edge 1, score after edge 2.
    pulse(8'h01, 8'h00, 8'h00, 1'b0);
    chk("t1_busy_e1",  32'(score_busy), 32'd1);
    chk("t1_score_e1", 32'(score_bcd), 32'd0);
    tick();
    chk("t1_busy_e2", 32'(score_busy), 32'd0);
    drain_check("t1_score");

    // Mixed burst of 9 points, then BCD carry.
    pulse(8'h00, 8'h00, 8'h00, 1'b1);
    drain_check("t2_clear");
    pulse(8'h03, 8'h01, 8'h01, 1'b0);
    cnt = 0;
    while (score_busy && cnt < 50) begin
      cnt++;
      tick();
    end
    chk("t2_busy_cycles", 32'(cnt), 32'd9);
    drain_check("t2_score9");
    pulse(8'h01, 8'h00, 8'h00, 1'b0);
    tick();
    drain_check("t2_carry");

    // Preload to 9995, then +10 saturates at 9999.
    pulse(8'h00, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 249; i++) pulse(8'h00, 8'h00, 8'hFF, 1'b0);
    pulse(8'h00, 8'h00, 8'h7F, 1'b0);
    drain_check("t3_9995");
    chk("t3_max_pre", 32'(score_max), 32'd0);
    pulse(8'h00, 8'h00, 8'h01, 1'b0);
    pulse(8'h00, 8'h00, 8'h01, 1'b0);
    drain_check("t3_sat");
    chk("t3_max", 32'(score_max), 32'd1);
    pulse(8'hFF, 8'h00, 8'h00, 1'b0);
    chk("t3_busy_sat", 32'(score_busy), 32'd0);
    tick(); tick(); tick();
    drain_check("t3_hold");

    // Clear beats a same-cycle hit, tone still starts.
    pulse(8'h00, 8'hFF, 8'h00, 1'b1);
    chk("t4_score", 32'(score_bcd), 32'd0);
    chk("t4_busy",  32'(score_busy), 32'd0);
    chk("t4_max",   32'(score_max), 32'd0);
    chk("t4_buzz",  32'(hit_buzz), 32'd1);
    exp_q.delete();

    // Single hit tone shape.
    for (int i = 0; i < HIT + 5; i++) tick();
    chk("t5_idle", 32'(hit_buzz), 32'd0);
    pulse(8'h01, 8'h00, 8'h00, 1'b0);
    chk("t5_k0", 32'(hit_buzz), 32'(exp_buzz(0)));
    for (int k = 1; k <= HIT + 3; k++) begin
      tick();
      chk($sformatf("t5_k%0d", k), 32'(hit_buzz), 32'(exp_buzz(k)));
    end

    // Retrigger at cycle 10 extends the tone to cycle 30.
    pulse(8'h01, 8'h00, 8'h00, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      if (k == 10) pulse(8'h00, 8'h01, 8'h00, 1'b0);
      else tick();
      chk($sformatf("t5r_k%0d", k), 32'(hit_buzz),
          32'(k < 10 ? exp_buzz(k) : exp_buzz(k - 10)));
    end
    drain_check("t5_score");

    // Asynchronous reset mid-drain and mid-tone.
    pulse(8'h00, 8'h00, 8'hFF, 1'b0);
    tick(); tick();
    chk("t6_busy_pre", 32'(score_busy), 32'd1);
    chk("t6_buzz_pre", 32'(hit_buzz), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_score", 32'(score_bcd), 32'd0);
    chk("t6_busy",  32'(score_busy), 32'd0);
    chk("t6_max",   32'(score_max), 32'd0);
    chk("t6_buzz",  32'(hit_buzz), 32'd0);
    exp_q.delete();
    model_score = 0;
    @(negedge clk25);
    reset_n = 1'b1;
    tick();
    chk("t6_post_score", 32'(score_bcd), 32'd0);
    chk("t6_post_buzz",  32'(hit_buzz), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hit_score_tracker.md
Name: hit_score_tracker

Overview:
Consumes the per-bullet hit vectors produced by the fly, mosquito and spider enemy controllers. Converts them into weighted points and keeps a 4-digit BCD score that counts up one unit per clock. Also generates the one-shot square-wave hit sound, which the top level ORs into the buzzer output next to the BGM and fire sounds. Sits directly downstream of the enemy controllers, in the clk25 domain.

Parameters:
BULLET_COUNT, 8, width of each hit vector
PTS_FLY, 1, points per fly hit
PTS_MOSQUITO, 2, points per mosquito hit
PTS_SPIDER, 5, points per spider hit
HALF_PERIOD, 12500, clk25 cycles per tone half-period (1 kHz at 25 MHz)
HIT_CYCLES, 2500000, tone duration in clk25 cycles (100 ms)

Ports:
clk25  in  1  pixel/system clock, about 25 MHz; the only clock
reset_n  in  1  asynchronous, active-low reset
clear_score  in  1  synchronous clear of score and pending points
bullet_hit_fly  in  BULLET_COUNT  one bit per bullet that hit a fly this cycle
bullet_hit_mosquito  in  BULLET_COUNT  one bit per bullet that hit a mosquito this cycle
bullet_hit_spider  in  BULLET_COUNT  one bit per bullet that hit the spider this cycle
score_bcd  out  16  four BCD digits; [15:12] is thousands
score_busy  out  1  high while pending points are non-zero
score_max  out  1  high when score_bcd == 16'h9999
hit_buzz  out  1  square-wave hit tone; low when idle

Behaviour:
- Reset (reset_n low, asynchronous):
  - score_bcd = 0, pending = 0, score_busy = 0, score_max = 0, hit_buzz = 0.
  - Tone duration and phase counters = 0.
  - Leaving reset is synchronous to clk25.
- Input sampling:
  - Every set bit in a hit vector is counted in every cycle it is high; inputs are expected to be 1-cycle pulses.
  - add = popcount(fly)*PTS_FLY + popcount(mosquito)*PTS_MOSQUITO + popcount(spider)*PTS_SPIDER.
  - add is computed combinationally; worst case with defaults is 64, so it fits in 7 bits.
- Pending accumulator:
  - 16-bit binary register.
  - Each edge: pending <= pending - dec + add, where dec = 1 if pending != 0 and the score is not saturated, else 0.
  - The sum saturates at 16'hFFFF; it never wraps.
- Score drain:
  - On each edge where dec = 1, score_bcd increments by one BCD unit.
  - Carry ripples: a digit at 9 becomes 0 and carries into the next digit.
  - Latency: a hit sampled at edge N is added to pending at N; score_bcd shows +1 after edge N+1.
  - A burst of P points takes P cycles to drain.
- Saturation:
  - When score_bcd == 9999, score_max = 1 and the score holds.
  - In the same edge pending is forced to 0, and further adds are discarded while saturated.
- score_busy is registered and equals (pending != 0) after each edge.
- clear_score:
  - Has priority over hits in the same cycle; those hits are dropped from the score.
  - Sets score_bcd = 0 and pending = 0 on the next edge.
  - Does not affect the tone.
- Hit tone:
  - any_hit = OR of all three hit vectors.
  - Edge with any_hit: duration counter <= HIT_CYCLES, phase counter <= 0, hit_buzz <= 1. This retriggers even if a tone is already playing.
  - Otherwise, while the duration counter != 0:
    - the duration counter decrements;
    - the phase counter increments;
    - when the phase counter reaches HALF_PERIOD-1, it returns to 0 and hit_buzz toggles.
  - When the duration counter is 0, hit_buzz <= 0 and the phase counter holds at 0.
  - The tone still triggers on hits that occur while the score is saturated or while clear_score is high.
- All outputs are registered, so there are no combinational paths from inputs to outputs.
- Reset asserted mid-drain or mid-tone returns every output to its reset value immediately.

Test Plan:
- Reset, then one pulse of bullet_hit_fly = 8'b0000_0001: pending = 1 after edge 1; score_bcd = 16'h0001 and score_busy = 0 after edge 2.
- Same cycle: fly = 8'h03, mosquito = 8'h01, spider = 8'h01 (add = 2+2+5 = 9): score_busy stays high 9 cycles, then score_bcd = 16'h0009. A further +1 gives 16'h0010, checking BCD carry.
- Preload score to 9995 with stream of hits, then spider hit ×2 (+10): score_bcd stops at 16'h9999, score_max = 1, pending = 0, and later hits do not change the score.
- clear_score asserted in the same cycle as mosquito = 8'hFF: score_bcd = 0 and pending = 0 next edge; hit_buzz still starts.
- With HALF_PERIOD = 4 and HIT_CYCLES = 20, a single hit: hit_buzz is high 4 cycles, low 4 cycles, repeating, and is 0 after 20 cycles. A second hit at cycle 10 restarts the high phase and extends the tone to cycle 30.
- Drop reset_n asynchronously mid-drain and mid-tone: all outputs are 0 within the same cycle, with no clock edge required.
